// File: rtl/debug_pkg.sv
// Shared constants for the board debug helper: button indices and count.
package debug_pkg;
  localparam int NUM_BTNS = 2;
  localparam int BTN_RST  = 0;
  localparam int BTN_MUX  = 1;
endpackage

// File: rtl/debug_button_conditioner.sv
// Raw button -> 2-FF sync, rising-edge detect, lockout counter, one-cycle pulse.
module button_conditioner #(
  parameter int DZ_WIDTH = 3
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse
);
  logic s1, s2, s3;
  logic [DZ_WIDTH-1:0] lock;
  logic rise;

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      lock    <= '0;
      o_pulse <= 1'b0;
    end else begin
      s1      <= i_btn;
      s2      <= s1;
      s3      <= s2;
      o_pulse <= 1'b0;
      // Rises during lockout are dropped outright, never deferred.
      if (rise && lock == '0) begin
        o_pulse <= 1'b1;
        lock    <= '1;
      end else if (lock != '0) begin
        lock <= lock - DZ_WIDTH'(1);
      end
    end
  end
endmodule

// File: rtl/debug.sv
// Debug helper top: button conditioning, bus selector, registered mux, soft-reset stretcher.
module debug
  import debug_pkg::*;
#(
  parameter int WIDTH              = 8,
  parameter int CMUX_N_STATES      = 4,
  parameter int DEADZONE_WIDTH     = 3,
  parameter int MUX_DEADZONE_WIDTH = 5
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic [NUM_BTNS-1:0] i_buttons,
  output logic [NUM_BTNS-1:0] o_buttons,
  input  logic [WIDTH-1:0]    i_cmux_in [CMUX_N_STATES],
  output logic [WIDTH-1:0]    o_cmux_out,
  output logic                o_reset
);
  localparam int SEL_W = $clog2(CMUX_N_STATES);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(CMUX_N_STATES - 1);

  logic [SEL_W-1:0]          sel;
  logic [DEADZONE_WIDTH-1:0] stretch;

  for (genvar k = 0; k < NUM_BTNS; k++) begin : g_btn
    button_conditioner #(
      .DZ_WIDTH(k == BTN_RST ? DEADZONE_WIDTH : MUX_DEADZONE_WIDTH)
    ) u_cond (
      .clk    (clk),
      .i_reset(i_reset),
      .i_btn  (i_buttons[k]),
      .o_pulse(o_buttons[k])
    );
  end

  // Soft reset takes priority over a simultaneous step.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      sel <= '0;
    end else if (o_buttons[BTN_RST]) begin
      sel <= '0;
    end else if (o_buttons[BTN_MUX]) begin
      sel <= (sel == SEL_MAX) ? '0 : sel + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) o_cmux_out <= '0;
    else          o_cmux_out <= i_cmux_in[sel];
  end

  // Load all-ones on the pulse edge: low for that cycle plus the countdown.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      stretch <= '0;
      o_reset <= 1'b0;
    end else if (o_buttons[BTN_RST]) begin
      stretch <= '1;
      o_reset <= 1'b0;
    end else if (stretch != '0) begin
      stretch <= stretch - DEADZONE_WIDTH'(1);
      o_reset <= 1'b0;
    end else begin
      o_reset <= 1'b1;
    end
  end
endmodule

// File: tb/tb_debug.sv
// Self-checking bench for debug: directed scenarios plus random stimulus against an event-time model.
module tb_debug;
  localparam int WIDTH = 8, N = 4, DZ = 3, MDZ = 5;

  logic             clk = 1'b0;
  logic             i_reset;
  logic [1:0]       i_buttons;
  logic [1:0]       o_buttons;
  logic [WIDTH-1:0] i_cmux_in [N];
  logic [WIDTH-1:0] o_cmux_out;
  logic             o_reset;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  debug #(.WIDTH(WIDTH), .CMUX_N_STATES(N), .DEADZONE_WIDTH(DZ), .MUX_DEADZONE_WIDTH(MDZ)) dut (
    .clk(clk), .i_reset(i_reset), .i_buttons(i_buttons), .o_buttons(o_buttons),
    .i_cmux_in(i_cmux_in), .o_cmux_out(o_cmux_out), .o_reset(o_reset)
  );

  // Reference model: presses are timestamped by edge number; a press seen at edge n
  // is due as a pulse after edge n+2 and accepted if the last accepted pulse of that
  // button is at least 2^W edges earlier.
  int         t = 0;
  int         m_sel, low_until;
  int         last_acc [2];
  int         due [2];
  bit         prev [2];
  int         lock_len [2];
  logic [1:0] m_btn;
  logic [7:0] m_out;
  logic       m_rst;

  task automatic model_clear();
    m_btn = 2'b00; m_out = '0; m_rst = 1'b0; m_sel = 0; low_until = -1000;
    for (int k = 0; k < 2; k++) begin
      last_acc[k] = -1000; due[k] = -1; prev[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    t++;
    m_out = i_cmux_in[m_sel];
    if (m_btn[0]) begin
      m_sel = 0;
      low_until = t + (1 << DZ) - 1;
    end else if (m_btn[1]) begin
      m_sel = (m_sel + 1) % N;
    end
    m_rst = (t > low_until);
    for (int k = 0; k < 2; k++) begin
      m_btn[k] = 1'b0;
      if (due[k] == t) begin
        due[k] = -1;
        if (t - last_acc[k] >= lock_len[k]) begin
          m_btn[k] = 1'b1;
          last_acc[k] = t;
        end
      end
      if (i_buttons[k] && !prev[k]) due[k] = t + 2;
      prev[k] = i_buttons[k];
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!i_reset) model_clear();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_buttons = 2'b00;
    i_cmux_in[0] = 8'h00; i_cmux_in[1] = 8'h11; i_cmux_in[2] = 8'h22; i_cmux_in[3] = 8'h33;
    model_clear();
    repeat (2) step();
    tests++;
    if ({o_reset, o_buttons, o_cmux_out} !== 11'h000) begin
      fails++;
      $display("FAIL reset_hold got rst=%b btn=%b out=%h exp all zero", o_reset, o_buttons, o_cmux_out);
    end
    i_reset = 1'b1;
    step();
    tests++;
    if (o_reset !== 1'b1 || o_cmux_out !== 8'h00 || o_buttons !== 2'b00) begin
      fails++;
      $display("FAIL reset_release got rst=%b btn=%b out=%h exp rst=1 btn=00 out=00", o_reset, o_buttons, o_cmux_out);
    end
  endtask

  task automatic test_both_held();
    int pulses = 0, pulse_at = -1, low = 0, bad = 0;
    for (int c = 1; c <= 40; c++) begin
      i_buttons = (c <= 5) ? 2'b11 : 2'b00;
      step();
      if (o_buttons == 2'b11) begin pulses++; pulse_at = c; end
      if (o_buttons == 2'b01 || o_buttons == 2'b10) bad++;
      if (o_reset == 1'b0) low++;
      tests++;
      if ({o_reset, o_buttons, o_cmux_out} !== {m_rst, m_btn, m_out}) begin
        fails++;
        $display("FAIL both_held c=%0d got rst=%b btn=%b out=%h exp rst=%b btn=%b out=%h",
                 c, o_reset, o_buttons, o_cmux_out, m_rst, m_btn, m_out);
      end
    end
    tests++;
    if (pulses !== 1 || pulse_at !== 3 || bad !== 0) begin
      fails++;
      $display("FAIL both_pulse got pulses=%0d at=%0d split=%0d exp pulses=1 at=3 split=0", pulses, pulse_at, bad);
    end
    tests++;
    if (low !== 8) begin
      fails++;
      $display("FAIL both_stretch got low=%0d exp 8", low);
    end
  endtask

  task automatic test_mux_step();
    logic [7:0] exp_seq [4];
    int pulses = 0;
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h00;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 50; c++) begin
        i_buttons = (c == 0) ? 2'b10 : 2'b00;
        step();
        if (o_buttons[1]) pulses++;
        tests++;
        if ({o_reset, o_buttons, o_cmux_out} !== {m_rst, m_btn, m_out}) begin
          fails++;
          $display("FAIL mux_step p=%0d c=%0d got rst=%b btn=%b out=%h exp rst=%b btn=%b out=%h",
                   p, c, o_reset, o_buttons, o_cmux_out, m_rst, m_btn, m_out);
        end
      end
      tests++;
      if (o_cmux_out !== exp_seq[p]) begin
        fails++;
        $display("FAIL mux_value p=%0d got %h exp %h", p, o_cmux_out, exp_seq[p]);
      end
    end
    tests++;
    if (pulses !== 4) begin
      fails++;
      $display("FAIL mux_pulses got %0d exp 4", pulses);
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int c = 0; c < 50; c++) begin
      i_buttons = (c == 0 || c == 10) ? 2'b10 : 2'b00;
      step();
      if (o_buttons[1]) pulses++;
      tests++;
      if ({o_reset, o_buttons, o_cmux_out} !== {m_rst, m_btn, m_out}) begin
        fails++;
        $display("FAIL bounce c=%0d got rst=%b btn=%b out=%h exp rst=%b btn=%b out=%h",
                 c, o_reset, o_buttons, o_cmux_out, m_rst, m_btn, m_out);
      end
    end
    tests++;
    if (pulses !== 1 || o_cmux_out !== 8'h11) begin
      fails++;
      $display("FAIL bounce_drop got pulses=%0d out=%h exp pulses=1 out=11", pulses, o_cmux_out);
    end
    for (int c = 0; c < 40; c++) begin
      i_buttons = (c == 0) ? 2'b10 : 2'b00;
      step();
      if (o_buttons[1]) pulses++;
    end
    tests++;
    if (pulses !== 2 || o_cmux_out !== 8'h22) begin
      fails++;
      $display("FAIL bounce_repress got pulses=%0d out=%h exp pulses=2 out=22", pulses, o_cmux_out);
    end
  endtask

  task automatic test_async_reset();
    #2 i_reset = 1'b0;
    #1;
    tests++;
    if (o_cmux_out !== 8'h00 || o_reset !== 1'b0 || o_buttons !== 2'b00) begin
      fails++;
      $display("FAIL async_reset got rst=%b btn=%b out=%h exp all zero", o_reset, o_buttons, o_cmux_out);
    end
    model_clear();
    @(negedge clk);
    step();
    i_reset = 1'b1;
    i_cmux_in[0] = 8'h5a;
    step();
    tests++;
    if (o_cmux_out !== 8'h5a || o_reset !== 1'b1) begin
      fails++;
      $display("FAIL async_release got rst=%b out=%h exp rst=1 out=5a", o_reset, o_cmux_out);
    end
    i_cmux_in[0] = 8'h00;
    step();
  endtask

  task automatic test_soft_reset();
    int low = 0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 40; c++) begin
        i_buttons = (c == 0) ? 2'b10 : 2'b00;
        step();
      end
    end
    tests++;
    if (o_cmux_out !== 8'h33) begin
      fails++;
      $display("FAIL soft_setup got out=%h exp 33", o_cmux_out);
    end
    for (int c = 0; c < 20; c++) begin
      i_buttons = (c == 0) ? 2'b01 : 2'b00;
      step();
      if (o_reset == 1'b0) low++;
      tests++;
      if ({o_reset, o_buttons, o_cmux_out} !== {m_rst, m_btn, m_out}) begin
        fails++;
        $display("FAIL soft_reset c=%0d got rst=%b btn=%b out=%h exp rst=%b btn=%b out=%h",
                 c, o_reset, o_buttons, o_cmux_out, m_rst, m_btn, m_out);
      end
    end
    tests++;
    if (low !== 8 || o_cmux_out !== 8'h00 || o_reset !== 1'b1) begin
      fails++;
      $display("FAIL soft_result got low=%0d out=%h rst=%b exp low=8 out=00 rst=1", low, o_cmux_out, o_reset);
    end
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < 40; c++) begin
      i_buttons = (c == 0) ? 2'b10 : 2'b00;
      step();
    end
    tests++;
    if (o_cmux_out !== 8'h11) begin
      fails++;
      $display("FAIL simul_setup got out=%h exp 11", o_cmux_out);
    end
    for (int c = 0; c < 40; c++) begin
      i_buttons = (c == 0) ? 2'b11 : 2'b00;
      step();
    end
    tests++;
    if (o_cmux_out !== 8'h00 || o_reset !== 1'b1) begin
      fails++;
      $display("FAIL simul_priority got out=%h rst=%b exp out=00 rst=1", o_cmux_out, o_reset);
    end
  endtask

  task automatic test_random();
    logic [1:0] b = 2'b00;
    int rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_hold > 0) begin
        i_reset = 1'b0; rst_hold--;
      end else begin
        i_reset = 1'b1;
        if ($urandom_range(0, 399) == 0) rst_hold = $urandom_range(1, 3);
      end
      if (b == 2'b00 && $urandom_range(0, 49) == 0) b = 2'b11;
      else for (int k = 0; k < 2; k++) if ($urandom_range(0, 7) == 0) b[k] = ~b[k];
      i_buttons = b;
      if ($urandom_range(0, 3) == 0) i_cmux_in[$urandom_range(0, N - 1)] = 8'($urandom);
      step();
      tests++;
      if ({o_reset, o_buttons, o_cmux_out} !== {m_rst, m_btn, m_out}) begin
        fails++;
        $display("FAIL random c=%0d got rst=%b btn=%b out=%h exp rst=%b btn=%b out=%h",
                 c, o_reset, o_buttons, o_cmux_out, m_rst, m_btn, m_out);
      end
    end
    i_buttons = 2'b00;
    i_reset = 1'b1;
  endtask

  initial begin
    lock_len[0] = 1 << DZ;
    lock_len[1] = 1 << MDZ;
    test_reset();
    test_both_held();
    test_mux_step();
    test_bounce();
    test_async_reset();
    test_soft_reset();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
